// File: rtl/vc_dest_arbiter.sv
// -----------------------------------------------------------------------------
// vc_dest_arbiter
//
// Purpose:
//   Pops words from two virtual-channel FIFOs (VC0, VC1) and forwards them to
//   one of two destination FIFOs (D0, D1). Bit 4 of each word selects the
//   destination. VC0 has strict priority, except that after MAX_STREAK
//   back-to-back VC0 grants with VC1 waiting, an eligible VC1 gets one grant.
//   A VC whose destination is almost full is skipped, so it never blocks the
//   other VC. The block starts in CONFIG. An init pulse latches the two
//   thresholds and moves it to RUN, where it stays until reset.
//
// Ports:
//   clk                              rising-edge clock
//   reset                            synchronous, active-high reset
//   init                             CONFIG -> RUN, latches Umbral_D0/D1
//   Umbral_D0, Umbral_D1             raw thresholds (4 bits each)
//   data_out_VC0, data_out_VC1       FWFT head word of each VC FIFO
//   empty_fifo_VC0, empty_fifo_VC1   VC FIFO empty flags
//   almost_full_D0, almost_full_D1   destination backpressure
//   pop_VC0_fifo, pop_VC1_fifo       combinational pop strobes (grant)
//   push_D0, push_D1                 registered destination write strobes
//   data_out                         registered word that goes with push_Dx
//   Umbral_D0_cfg, Umbral_D1_cfg     latched thresholds
//   active                           high in RUN
//   idle                             RUN, both VCs empty, no push in flight
//   count_D0, count_D1               words forwarded per destination, mod 256
// -----------------------------------------------------------------------------

// Property checker for the arbiter's internal invariants.
module vc_dest_arbiter_chk #(
    parameter int MAX_STREAK = 4
) (
    input logic       clk,
    input logic       reset,
    input logic       pop_vc0,
    input logic       pop_vc1,
    input logic       push_d0,
    input logic       push_d1,
    input logic [3:0] streak
);
    localparam logic [3:0] MAX_STREAK_C = 4'(MAX_STREAK);

    // Only one VC may be granted in a cycle.
    a_one_pop : assert property (@(posedge clk) disable iff (reset)
        !(pop_vc0 && pop_vc1));

    // Only one destination may be written in a cycle.
    a_one_push : assert property (@(posedge clk) disable iff (reset)
        !(push_d0 && push_d1));

    // The fairness counter saturates at its limit.
    a_streak_bound : assert property (@(posedge clk) disable iff (reset)
        streak <= MAX_STREAK_C);
endmodule

module vc_dest_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int MAX_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [3:0]            Umbral_D0,
    input  logic [3:0]            Umbral_D1,
    input  logic [DATA_WIDTH-1:0] data_out_VC0,
    input  logic [DATA_WIDTH-1:0] data_out_VC1,
    input  logic                  empty_fifo_VC0,
    input  logic                  empty_fifo_VC1,
    input  logic                  almost_full_D0,
    input  logic                  almost_full_D1,
    output logic                  pop_VC0_fifo,
    output logic                  pop_VC1_fifo,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [3:0]            Umbral_D0_cfg,
    output logic [3:0]            Umbral_D1_cfg,
    output logic                  active,
    output logic                  idle,
    output logic [7:0]            count_D0,
    output logic [7:0]            count_D1
);
    localparam int         DEST_BIT     = 4;
    localparam logic [3:0] MAX_STREAK_C = 4'(MAX_STREAK);

    typedef enum logic [0:0] {
        ST_CONFIG = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  run_s;
    logic                  elig_vc0_s;
    logic                  elig_vc1_s;
    logic                  grant_vc0_s;
    logic                  grant_vc1_s;
    logic                  grant_any_s;
    logic [DATA_WIDTH-1:0] grant_word_s;
    logic [3:0]            streak_r;
    logic [3:0]            streak_next_s;
    logic                  push_d0_r;
    logic                  push_d1_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [7:0]            count_d0_r;
    logic [7:0]            count_d1_r;
    logic [3:0]            cfg_d0_r;
    logic [3:0]            cfg_d1_r;

    // Backpressure seen by a head word: the almost_full of the destination it targets.
    function automatic logic dest_blocked(input logic [DATA_WIDTH-1:0] word,
                                          input logic af_d0,
                                          input logic af_d1);
        logic blocked;
        if (word[DEST_BIT]) begin
            blocked = af_d1;
        end else begin
            blocked = af_d0;
        end
        return blocked;
    endfunction

    // Control state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_CONFIG;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: CONFIG leaves on init, RUN is left only through reset.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CONFIG: begin
                if (init) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CONFIG;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_CONFIG;
        endcase
    end

    assign run_s = (state_r == ST_RUN);

    // Eligibility per VC: has a word and its destination can accept it.
    always_comb begin
        elig_vc0_s = 1'b0;
        elig_vc1_s = 1'b0;
        if (run_s && !reset) begin
            elig_vc0_s = !empty_fifo_VC0 &&
                         !dest_blocked(data_out_VC0, almost_full_D0, almost_full_D1);
            elig_vc1_s = !empty_fifo_VC1 &&
                         !dest_blocked(data_out_VC1, almost_full_D0, almost_full_D1);
        end else begin
            elig_vc0_s = 1'b0;
            elig_vc1_s = 1'b0;
        end
    end

    // Grant selection: VC0 first unless VC1 has waited through a full streak.
    always_comb begin
        grant_vc0_s = 1'b0;
        grant_vc1_s = 1'b0;
        if ((streak_r == MAX_STREAK_C) && elig_vc1_s) begin
            grant_vc1_s = 1'b1;
        end else if (elig_vc0_s) begin
            grant_vc0_s = 1'b1;
        end else if (elig_vc1_s) begin
            grant_vc1_s = 1'b1;
        end else begin
            grant_vc0_s = 1'b0;
            grant_vc1_s = 1'b0;
        end
    end

    assign grant_any_s = grant_vc0_s || grant_vc1_s;

    // Head word of whichever VC won this cycle.
    always_comb begin
        grant_word_s = data_out_VC0;
        if (grant_vc1_s) begin
            grant_word_s = data_out_VC1;
        end else begin
            grant_word_s = data_out_VC0;
        end
    end

    // Streak update. It counts VC0 wins only while VC1 is waiting, and it saturates
    // so that a blocked VC1 cannot push it past the limit.
    always_comb begin
        streak_next_s = streak_r;
        if (!run_s) begin
            streak_next_s = streak_r;
        end else if (grant_vc1_s || empty_fifo_VC1) begin
            streak_next_s = 4'd0;
        end else if (grant_vc0_s) begin
            if (streak_r < MAX_STREAK_C) begin
                streak_next_s = streak_r + 4'd1;
            end else begin
                streak_next_s = MAX_STREAK_C;
            end
        end else begin
            streak_next_s = streak_r;
        end
    end

    // Fairness counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_r <= 4'd0;
        end else begin
            streak_r <= streak_next_s;
        end
    end

    // Threshold latch: sampled only on the init cycle that leaves CONFIG.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_d0_r <= 4'd0;
            cfg_d1_r <= 4'd0;
        end else if ((state_r == ST_CONFIG) && init) begin
            cfg_d0_r <= Umbral_D0;
            cfg_d1_r <= Umbral_D1;
        end else begin
            cfg_d0_r <= cfg_d0_r;
            cfg_d1_r <= cfg_d1_r;
        end
    end

    // Output stage: one cycle after a grant, present the word and strobe its destination.
    always_ff @(posedge clk) begin
        if (reset) begin
            push_d0_r <= 1'b0;
            push_d1_r <= 1'b0;
            data_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            push_d0_r <= grant_any_s && !grant_word_s[DEST_BIT];
            push_d1_r <= grant_any_s &&  grant_word_s[DEST_BIT];
            if (grant_any_s) begin
                data_r <= grant_word_s;
            end else begin
                data_r <= data_r;
            end
        end
    end

    // Per-destination forwarded-word counters, free-running modulo 256.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_d0_r <= 8'd0;
            count_d1_r <= 8'd0;
        end else begin
            count_d0_r <= count_d0_r + {7'd0, push_d0_r};
            count_d1_r <= count_d1_r + {7'd0, push_d1_r};
        end
    end

    assign pop_VC0_fifo  = grant_vc0_s;
    assign pop_VC1_fifo  = grant_vc1_s;
    assign push_D0       = push_d0_r;
    assign push_D1       = push_d1_r;
    assign data_out      = data_r;
    assign Umbral_D0_cfg = cfg_d0_r;
    assign Umbral_D1_cfg = cfg_d1_r;
    assign count_D0      = count_d0_r;
    assign count_D1      = count_d1_r;
    assign active        = run_s;
    assign idle          = run_s && empty_fifo_VC0 && empty_fifo_VC1 &&
                           !push_d0_r && !push_d1_r;

    vc_dest_arbiter_chk #(
        .MAX_STREAK (MAX_STREAK)
    ) u_chk (
        .clk     (clk),
        .reset   (reset),
        .pop_vc0 (grant_vc0_s),
        .pop_vc1 (grant_vc1_s),
        .push_d0 (push_d0_r),
        .push_d1 (push_d1_r),
        .streak  (streak_r)
    );
endmodule

// File: tb/tb_vc_dest_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_dest_arbiter
//
// Self-checking bench for vc_dest_arbiter (DATA_WIDTH=6, MAX_STREAK=4).
// Directed scenarios are followed by a randomized phase. Every cycle the DUT
// is compared with a behavioural reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_vc_dest_arbiter;
    localparam int MAXS = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [3:0] Umbral_D0;
    logic [3:0] Umbral_D1;
    logic [5:0] data_out_VC0;
    logic [5:0] data_out_VC1;
    logic       empty_fifo_VC0;
    logic       empty_fifo_VC1;
    logic       almost_full_D0;
    logic       almost_full_D1;
    logic       pop_VC0_fifo;
    logic       pop_VC1_fifo;
    logic       push_D0;
    logic       push_D1;
    logic [5:0] data_out;
    logic [3:0] Umbral_D0_cfg;
    logic [3:0] Umbral_D1_cfg;
    logic       active;
    logic       idle;
    logic [7:0] count_D0;
    logic [7:0] count_D1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit         m_run    = 1'b0;
    int         m_streak = 0;
    bit         m_push0  = 1'b0;
    bit         m_push1  = 1'b0;
    logic [5:0] m_data   = 6'd0;
    int         m_cnt0   = 0;
    int         m_cnt1   = 0;
    logic [3:0] m_cfg0   = 4'd0;
    logic [3:0] m_cfg1   = 4'd0;
    int         dut_log[$];

    always #5 clk = ~clk;

    vc_dest_arbiter #(.DATA_WIDTH(6), .MAX_STREAK(MAXS)) dut (
        .clk            (clk),
        .reset          (reset),
        .init           (init),
        .Umbral_D0      (Umbral_D0),
        .Umbral_D1      (Umbral_D1),
        .data_out_VC0   (data_out_VC0),
        .data_out_VC1   (data_out_VC1),
        .empty_fifo_VC0 (empty_fifo_VC0),
        .empty_fifo_VC1 (empty_fifo_VC1),
        .almost_full_D0 (almost_full_D0),
        .almost_full_D1 (almost_full_D1),
        .pop_VC0_fifo   (pop_VC0_fifo),
        .pop_VC1_fifo   (pop_VC1_fifo),
        .push_D0        (push_D0),
        .push_D1        (push_D1),
        .data_out       (data_out),
        .Umbral_D0_cfg  (Umbral_D0_cfg),
        .Umbral_D1_cfg  (Umbral_D1_cfg),
        .active         (active),
        .idle           (idle),
        .count_D0       (count_D0),
        .count_D1       (count_D1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which VC the arbitration rules pick for the inputs currently driven (-1 = none).
    function automatic int model_grant();
        bit ok0;
        bit ok1;
        if (!m_run || reset) return -1;
        ok0 = !empty_fifo_VC0 && !(data_out_VC0[4] ? almost_full_D1 : almost_full_D0);
        ok1 = !empty_fifo_VC1 && !(data_out_VC1[4] ? almost_full_D1 : almost_full_D0);
        if (m_streak == MAXS && ok1) return 1;
        if (ok0) return 0;
        if (ok1) return 1;
        return -1;
    endfunction

    // One clock: drive inputs, check pops, clock, advance model, check registered outputs.
    task automatic cycle(input logic rst, input logic ini,
                         input logic [3:0] u0, input logic [3:0] u1,
                         input logic [5:0] h0, input logic [5:0] h1,
                         input logic e0, input logic e1,
                         input logic f0, input logic f1);
        int         g;
        logic [5:0] w;
        reset = rst; init = ini; Umbral_D0 = u0; Umbral_D1 = u1;
        data_out_VC0 = h0; data_out_VC1 = h1;
        empty_fifo_VC0 = e0; empty_fifo_VC1 = e1;
        almost_full_D0 = f0; almost_full_D1 = f1;
        #1;
        g = model_grant();
        check("pop_VC0", {31'd0, pop_VC0_fifo}, {31'd0, (g == 0)});
        check("pop_VC1", {31'd0, pop_VC1_fifo}, {31'd0, (g == 1)});
        dut_log.push_back(pop_VC1_fifo ? 1 : (pop_VC0_fifo ? 0 : -1));
        w = (g == 1) ? h1 : h0;
        @(posedge clk);
        #1;
        if (rst) begin
            m_run = 1'b0; m_streak = 0; m_push0 = 1'b0; m_push1 = 1'b0;
            m_data = 6'd0; m_cnt0 = 0; m_cnt1 = 0; m_cfg0 = 4'd0; m_cfg1 = 4'd0;
        end else begin
            m_cnt0 = (m_cnt0 + int'(m_push0)) % 256;
            m_cnt1 = (m_cnt1 + int'(m_push1)) % 256;
            m_push0 = (g >= 0) && !w[4];
            m_push1 = (g >= 0) && w[4];
            if (g >= 0) m_data = w;
            if (m_run) begin
                if (g == 1 || e1) m_streak = 0;
                else if (g == 0) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
            end else if (ini) begin
                m_cfg0 = u0; m_cfg1 = u1; m_run = 1'b1;
            end
        end
        check("push_D0",  {31'd0, push_D0},  {31'd0, m_push0});
        check("push_D1",  {31'd0, push_D1},  {31'd0, m_push1});
        check("data_out", {26'd0, data_out}, {26'd0, m_data});
        check("count_D0", {24'd0, count_D0}, m_cnt0);
        check("count_D1", {24'd0, count_D1}, m_cnt1);
        check("cfg_D0",   {28'd0, Umbral_D0_cfg}, {28'd0, m_cfg0});
        check("cfg_D1",   {28'd0, Umbral_D1_cfg}, {28'd0, m_cfg1});
        check("active",   {31'd0, active}, {31'd0, m_run});
        check("idle",     {31'd0, idle},
              {31'd0, (m_run && e0 && e1 && !m_push0 && !m_push1)});
    endtask

    initial begin
        int c0;
        // Reset, then a CONFIG cycle with VC data present that must be ignored.
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_data",   {26'd0, data_out}, 32'd0);
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'h05, 6'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        check("cfg_nopush", {31'd0, push_D0 | push_D1}, 32'd0);

        // Configuration latch, then a second init that must be ignored.
        cycle(1'b0, 1'b1, 4'd3, 4'd5, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("s29_cfg0",   {28'd0, Umbral_D0_cfg}, 32'd3);
        check("s29_cfg1",   {28'd0, Umbral_D1_cfg}, 32'd5);
        check("s29_active", {31'd0, active}, 32'd1);
        cycle(1'b0, 1'b1, 4'd9, 4'd12, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("s29_keep0",  {28'd0, Umbral_D0_cfg}, 32'd3);
        check("s29_keep1",  {28'd0, Umbral_D1_cfg}, 32'd5);

        // Single VC0 word to D0: one-cycle latency, then the counter.
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'h05, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("s30_push", {31'd0, push_D0}, 32'd1);
        check("s30_data", {26'd0, data_out}, 32'h05);
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        check("s30_cnt",  {24'd0, count_D0}, 32'd1);

        // Both VCs busy: four VC0 grants, then one VC1 grant, repeating.
        dut_log.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'($urandom_range(0, 63)),
                  6'($urandom_range(0, 63)), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            check("s31_pattern", dut_log[i], (i % 5 == 4) ? 32'd1 : 32'd0);
        end

        // VC0 blocked on D1 must not stall VC1 going to D0.
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'h12, 6'h03, 1'b0, 1'b0, 1'b0, 1'b1);
        check("s32_push0", {31'd0, push_D0}, 32'd1);
        check("s32_data",  {26'd0, data_out}, 32'h03);
        check("s32_push1", {31'd0, push_D1}, 32'd0);
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'h12, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        check("s32_hold1", {31'd0, push_D1}, 32'd0);
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'h12, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("s32_rel1",  {31'd0, push_D1}, 32'd1);
        check("s32_rdata", {26'd0, data_out}, 32'h12);

        // Reset the cycle after a grant: the push is dropped and the block returns to CONFIG.
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'h0a, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 6'h0b, 6'h1c, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s34_push",   {31'd0, push_D0 | push_D1}, 32'd0);
        check("s34_active", {31'd0, active}, 32'd0);
        check("s34_data",   {26'd0, data_out}, 32'd0);
        check("s34_cnt",    {24'd0, count_D0}, 32'd0);
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'h0b, 6'h1c, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s34_config", {31'd0, pop_VC0_fifo | active}, 32'd0);

        // 256 words to D0 from a fresh configuration: count_D0 wraps back to 0.
        cycle(1'b0, 1'b1, 4'd1, 4'd2, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'(i) & 6'h2f, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 6'h00, 6'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        c0 = int'(count_D0);
        check("s33_wrap", c0, 32'd0);

        // Randomized traffic, backpressure, stray init pulses and occasional resets.
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
